// File: rtl/vga_frame_writer.sv
// Captures an incoming 640x480 HS/VS/RGB444 stream into a linear 12-bit framebuffer.
// Tracks frame/line timing, skips blanking and reports broken sync. H_BACK must be at least 2.
module vga_frame_writer #(
    parameter int Wight  = 640,
    parameter int Height = 480,
    parameter int H_BACK = 48,
    parameter int V_BACK = 33
) (
    input  logic        clk_vga,
    input  logic        rst,
    input  logic        capture_en,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    input  logic [3:0]  VGA_R,
    input  logic [3:0]  VGA_G,
    input  logic [3:0]  VGA_B,
    output logic [18:0] wr_addr,
    output logic [11:0] wr_data,
    output logic        wr_en,
    output logic        busy,
    output logic        frame_done,
    output logic        sync_err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VS,
        V_BLANK,
        H_BLANK,
        ACTIVE,
        DONE
    } state_t;

    localparam logic [9:0]  X_LAST    = 10'(Wight - 1);
    localparam logic [8:0]  LINE_LAST = 9'(Height - 1);
    localparam logic [8:0]  LINE_CNT  = 9'(Height);
    localparam logic [18:0] LINE_STEP = 19'(Wight);
    localparam logic [7:0]  H_LAST    = 8'(H_BACK - 1);
    localparam logic [7:0]  V_LAST    = 8'(V_BACK);

    logic        hs_p1;
    logic        vs_p1;
    logic        hs_p2;
    logic        vs_p2;
    logic [11:0] rgb_p1;

    logic        hs_rise;
    logic        hs_fall;
    logic        vs_rise;
    logic        vs_fall;
    logic        early_vs;

    state_t      state;
    logic [8:0]  line;
    logic [18:0] base;
    logic [18:0] addr;
    logic [9:0]  x;
    logic [7:0]  hcnt;
    logic [7:0]  vcnt;
    logic        hrun;

    // Stage 1: sample the sync lines and colour; a second copy of the syncs feeds edge detection
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            hs_p1 <= 1'b1;
            vs_p1 <= 1'b1;
            hs_p2 <= 1'b1;
            vs_p2 <= 1'b1;
        end else begin
            hs_p1 <= VGA_HS;
            vs_p1 <= VGA_VS;
            hs_p2 <= hs_p1;
            vs_p2 <= vs_p1;
        end
    end

    always_ff @(posedge clk_vga) begin
        rgb_p1 <= {VGA_R, VGA_G, VGA_B};
    end

    assign hs_rise  = hs_p1 & ~hs_p2;
    assign hs_fall  = ~hs_p1 & hs_p2;
    assign vs_rise  = vs_p1 & ~vs_p2;
    assign vs_fall  = ~vs_p1 & vs_p2;
    assign early_vs = vs_fall & busy & (line < LINE_CNT);

    // Stage 2: timing FSM and registered write port
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            line       <= '0;
            base       <= '0;
            addr       <= '0;
            x          <= '0;
            hcnt       <= '0;
            vcnt       <= '0;
            hrun       <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            if (early_vs) begin
                // VS arrived before the frame was complete: drop it and resync on the next VS
                sync_err <= 1'b1;
                hrun     <= 1'b0;
                state    <= WAIT_VS;
            end else begin
                case (state)
                    IDLE: begin
                        if (capture_en) state <= WAIT_VS;
                    end
                    WAIT_VS: begin
                        if (!busy && !capture_en) begin
                            state <= IDLE;
                        end else if (vs_rise) begin
                            busy     <= 1'b1;
                            sync_err <= 1'b0;
                            line     <= '0;
                            base     <= '0;
                            vcnt     <= '0;
                            state    <= V_BLANK;
                        end
                    end
                    V_BLANK: begin
                        if (hs_rise) begin
                            if (vcnt == V_LAST) begin
                                hcnt  <= 8'd1;
                                hrun  <= 1'b1;
                                state <= H_BLANK;
                            end else begin
                                vcnt <= vcnt + 8'd1;
                            end
                        end
                    end
                    H_BLANK: begin
                        if (hs_rise) begin
                            hcnt <= 8'd1;
                            hrun <= 1'b1;
                        end else if (hrun && hcnt == H_LAST) begin
                            hrun  <= 1'b0;
                            x     <= '0;
                            addr  <= base;
                            state <= ACTIVE;
                        end else if (hrun) begin
                            hcnt <= hcnt + 8'd1;
                        end
                    end
                    ACTIVE: begin
                        if (hs_fall) begin
                            sync_err <= 1'b1;
                        end else begin
                            wr_en   <= 1'b1;
                            wr_addr <= addr;
                            wr_data <= rgb_p1;
                            addr    <= addr + 19'd1;
                            x       <= x + 10'd1;
                        end
                        // A short line still consumes its slot so later lines keep their addresses
                        if (hs_fall || x == X_LAST) begin
                            base  <= base + LINE_STEP;
                            line  <= line + 9'd1;
                            state <= (line == LINE_LAST) ? DONE : H_BLANK;
                        end
                    end
                    DONE: begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= capture_en ? WAIT_VS : IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_writer.sv
// Bench for vga_frame_writer on a reduced raster: random pixels, a frame-level write model
// and directed sync faults (short line, early VS, capture_en changes, mid-frame reset).
module tb_vga_frame_writer;

    localparam int W    = 16;
    localparam int H    = 6;
    localparam int HB   = 5;
    localparam int VB   = 3;
    localparam int HSW  = 3;
    localparam int HFP  = 4;
    localparam int VSW  = 2;
    localparam int VFP  = 2;
    localparam int NONE = -100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        capture_en = 1'b0;
    logic        VGA_HS = 1'b1;
    logic        VGA_VS = 1'b1;
    logic [3:0]  VGA_R = 4'h0;
    logic [3:0]  VGA_G = 4'h0;
    logic [3:0]  VGA_B = 4'h0;
    logic [18:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_en;
    logic        busy;
    logic        frame_done;
    logic        sync_err;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int fd_cnt = 0;
    int rst_left = 0;
    logic err_at_vs;
    logic busy_at_vs;
    logic err_end;
    logic busy_end;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;
    exp_t expq[$];

    vga_frame_writer #(
        .Wight (W),
        .Height(H),
        .H_BACK(HB),
        .V_BACK(VB)
    ) dut (
        .clk_vga   (clk),
        .rst       (rst),
        .capture_en(capture_en),
        .VGA_HS    (VGA_HS),
        .VGA_VS    (VGA_VS),
        .VGA_R     (VGA_R),
        .VGA_G     (VGA_G),
        .VGA_B     (VGA_B),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .busy      (busy),
        .frame_done(frame_done),
        .sync_err  (sync_err)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string when);
        check({when, "_wr_en"}, 32'(wr_en), 32'd0);
        check({when, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({when, "_wr_data"}, 32'(wr_data), 32'd0);
        check({when, "_busy"}, 32'(busy), 32'd0);
        check({when, "_frame_done"}, 32'(frame_done), 32'd0);
        check({when, "_sync_err"}, 32'(sync_err), 32'd0);
    endtask

    // Every write must match the oldest expected pixel and land two cycles after it was driven
    always @(negedge clk) begin
        exp_t e;
        if (frame_done) fd_cnt++;
        if (wr_en) begin
            if (expq.size() == 0) begin
                check("stray_wr_addr", 32'(wr_addr), 32'hFFFF_FFFF);
            end else begin
                e = expq.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", 32'(wr_data), 32'(e.data));
                check("wr_latency", 32'(cyc), 32'(e.cyc + 2));
            end
        end
    end

    task automatic drive(input logic hs_v, input logic vs_v, input logic [11:0] px);
        @(posedge clk);
        #1;
        VGA_HS = hs_v;
        VGA_VS = vs_v;
        {VGA_R, VGA_G, VGA_B} = px;
        if (rst_left > 0) begin
            rst_left--;
            if (rst_left == 0) rst = 1'b0;
        end
    endtask

    // One raster frame: VS low, back porch lines, H active lines, front porch lines.
    // Line = HS low HSW, back porch HB, W pixels, front porch HFP; a short line cuts pixels and porch.
    task automatic send_frame(input bit cap, input int short_y, input int short_len,
                              input int early_y, input int rst_y, input int drop_y,
                              input int raise_y, input int exp_fd);
        bit          live;
        bit          is_short;
        int          fd0;
        int          y;
        int          n;
        logic        vs_v;
        logic [11:0] px;
        live = cap;
        fd0 = fd_cnt;
        for (int ln = 0; ln < VSW + VB + H + VFP; ln++) begin
            y = ln - (VSW + VB);
            vs_v = (ln >= VSW);
            if (ln == VSW) begin
                err_at_vs = sync_err;
                busy_at_vs = busy;
            end
            repeat (HSW) drive(1'b0, vs_v, 12'h000);
            repeat (HB) drive(1'b1, vs_v, 12'h000);
            if (y == drop_y) capture_en = 1'b0;
            if (y == raise_y) capture_en = 1'b1;
            is_short = (y >= 0) && (y == short_y);
            n = is_short ? short_len : W;
            for (int i = 0; i < n; i++) begin
                px = (y >= 0 && y < H) ? 12'($urandom) : 12'h000;
                drive(1'b1, vs_v, px);
                if (live && y >= 0 && y < H) expq.push_back('{y * W + i, int'(px), cyc});
                if (y == rst_y && i == W / 2) begin
                    rst = 1'b1;
                    rst_left = 3;
                    live = 1'b0;
                    expq.delete();
                    #1;
                    check_outputs_zero("midframe_rst");
                end
            end
            if (!is_short) repeat (HFP) drive(1'b1, vs_v, 12'h000);
            if (y == early_y) break;
        end
        err_end = sync_err;
        busy_end = busy;
        check("frame_done_count", 32'(fd_cnt - fd0), 32'(exp_fd));
        check("pending_writes", 32'(expq.size()), 32'd0);
    endtask

    initial begin
        int sl;
        int sy;

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        // Nominal frame
        capture_en = 1'b1;
        send_frame(1'b1, NONE, 0, NONE, NONE, NONE, NONE, 1);
        check("t1_busy_at_vs", 32'(busy_at_vs), 32'd0);
        check("t1_sync_err", 32'(err_end), 32'd0);
        check("t1_busy_end", 32'(busy_end), 32'd0);

        // Short line 2, then a clean frame clears the error at its VS rise
        sl = $urandom_range(W - 1, 1);
        send_frame(1'b1, 2, sl, NONE, NONE, NONE, NONE, 1);
        check("t2_sync_err", 32'(err_end), 32'd1);
        check("t2_busy_end", 32'(busy_end), 32'd0);
        send_frame(1'b1, NONE, 0, NONE, NONE, NONE, NONE, 1);
        check("t2_err_held", 32'(err_at_vs), 32'd1);
        check("t2_err_cleared", 32'(err_end), 32'd0);

        // Early VS after line 2
        send_frame(1'b1, NONE, 0, 2, NONE, NONE, NONE, 0);
        check("t3_busy_cut", 32'(busy_end), 32'd1);
        send_frame(1'b1, NONE, 0, NONE, NONE, NONE, NONE, 1);
        check("t3_err_set", 32'(err_at_vs), 32'd1);
        check("t3_busy_held", 32'(busy_at_vs), 32'd1);
        check("t3_err_cleared", 32'(err_end), 32'd0);

        // capture_en dropped mid-frame: frame completes, next frame ignored
        send_frame(1'b1, NONE, 0, NONE, NONE, 2, NONE, 1);
        check("t4_busy_end", 32'(busy_end), 32'd0);
        send_frame(1'b0, NONE, 0, NONE, NONE, NONE, NONE, 0);
        check("t4_idle_busy", 32'(busy_end), 32'd0);

        // capture_en raised mid-frame: capture starts at the following frame
        send_frame(1'b0, NONE, 0, NONE, NONE, NONE, 2, 0);
        check("t6_busy_end", 32'(busy_end), 32'd0);
        send_frame(1'b1, NONE, 0, NONE, NONE, NONE, NONE, 1);
        check("t6_sync_err", 32'(err_end), 32'd0);

        // Reset during line 3, then a full frame from address 0
        send_frame(1'b1, NONE, 0, NONE, 3, NONE, NONE, 0);
        check("t5_busy_end", 32'(busy_end), 32'd0);
        send_frame(1'b1, NONE, 0, NONE, NONE, NONE, NONE, 1);
        check("t5_sync_err", 32'(err_end), 32'd0);

        // Random short line anywhere in the frame, including the last one
        sy = $urandom_range(H - 1, 0);
        sl = $urandom_range(W - 1, 1);
        send_frame(1'b1, sy, sl, NONE, NONE, NONE, NONE, 1);
        check("rand_short_err", 32'(err_end), 32'd1);
        send_frame(1'b1, NONE, 0, NONE, NONE, NONE, NONE, 1);
        check("rand_clean_err", 32'(err_end), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
